// File: rtl/bisection_wb_regs.sv
// Wishbone classic register block for the bisection root-finder core: coefficient load,
// start/settle/capture sequencing, done/overrun status and an optional done interrupt.
module bisection_wb_regs #(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int          SETTLE_CYCLES = 64,
    parameter int          CNT_W         = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        core_rst,
    output logic [15:0] core_z,
    input  logic [19:0] core_alpha,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CAPT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic [15:0]       coef_q, coef_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic [19:0]       result_q, result_d;

    logic              req;
    logic              addr_hit;
    logic [1:0]        reg_idx;
    logic              wr_commit;
    logic              busy;
    logic              idle;
    logic [31:0]       rd_data;
    logic              unused_bits;

    assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:16]};

    assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign addr_hit  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]) && (wbs_adr_i[1:0] == 2'b00);
    assign reg_idx   = wbs_adr_i[3:2];
    // Writes use the address/data the master still holds during the ack cycle.
    assign wr_commit = ack_q & wbs_cyc_i & wbs_stb_i & wbs_we_i & addr_hit;
    assign busy      = (state_q == ST_RUN);
    assign idle      = (state_q == ST_IDLE);

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    // Core stays running through the capture cycle so alpha is still valid when sampled.
    assign core_rst  = idle;
    assign core_z    = coef_q;
    assign irq       = done_q & irq_en_q;

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            2'd0:    rd_data = {16'd0, coef_q};
            2'd1:    rd_data = {30'd0, irq_en_q, 1'b0};
            2'd2:    rd_data = {29'd0, overrun_q, done_q, busy};
            default: rd_data = {12'd0, result_q};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        coef_d    = coef_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        overrun_d = overrun_q;
        result_d  = result_q;
        ack_d     = req;
        dat_d     = '0;

        if (req && !wbs_we_i && addr_hit) begin
            dat_d = rd_data;
        end

        if (wr_commit) begin
            case (reg_idx)
                2'd0: begin
                    if (!busy) begin
                        if (wbs_sel_i[0]) coef_d[7:0]  = wbs_dat_i[7:0];
                        if (wbs_sel_i[1]) coef_d[15:8] = wbs_dat_i[15:8];
                    end
                end
                2'd1: begin
                    if (wbs_sel_i[0]) begin
                        irq_en_d = wbs_dat_i[1];
                        if (wbs_dat_i[0]) begin
                            if (idle) begin
                                state_d = ST_RUN;
                                cnt_d   = '0;
                                done_d  = 1'b0;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end
                    end
                end
                2'd2: begin
                    if (wbs_sel_i[0]) begin
                        if (wbs_dat_i[1]) done_d    = 1'b0;
                        if (wbs_dat_i[2]) overrun_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // Evaluated after the bus write so a capture beats a same-cycle DONE clear.
        case (state_q)
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CAPT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CAPT: begin
                result_d = core_alpha;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            coef_q    <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            coef_q    <= coef_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_bisection_wb_regs.sv
// Scoreboard bench for bisection_wb_regs: directed scenarios followed by random bus traffic,
// checked against a cycle-window reference model of the register block.
module tb_bisection_wb_regs;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          S    = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0;
    logic [31:0] wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        core_rst;
    logic [15:0] core_z;
    logic [19:0] alpha_drv = 20'h0;
    logic        irq;

    bisection_wb_regs #(.BASE_ADDR(BASE), .SETTLE_CYCLES(S), .CNT_W(16)) dut (
        .clk(clk), .reset(rst_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .core_rst(core_rst), .core_z(core_z), .core_alpha(alpha_drv), .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    // Reference model: register values plus the window of cycles occupied by a run.
    logic [15:0] m_coef;
    bit          m_irq_en, m_done, m_ovr, pending;
    logic [19:0] m_result, cap_alpha, next_alpha;
    int          run_start, cap;

    function automatic void m_reset();
        m_coef = 0; m_irq_en = 0; m_done = 0; m_ovr = 0; m_result = 0;
        pending = 0; run_start = 0; cap = 0;
    endfunction

    // Apply a capture whose clock edge (end of cycle cap) lies before cycle c.
    function automatic void m_sync(int c);
        if (pending && cap < c) begin
            m_result = cap_alpha;
            m_done   = 1;
            pending  = 0;
        end
    endfunction

    function automatic bit m_busy(int c);
        return pending && c >= run_start && c <= run_start + S - 1;
    endfunction

    function automatic bit m_idle(int c);
        return !(pending && c >= run_start && c <= cap);
    endfunction

    function automatic bit m_hit(logic [31:0] adr);
        return (adr[31:4] == BASE[31:4]) && (adr[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] m_read(int c, logic [31:0] adr);
        logic [31:0] v;
        v = 32'h0;
        if (m_hit(adr)) begin
            case (adr[3:2])
                2'd0: v = {16'h0, m_coef};
                2'd1: v = {30'h0, m_irq_en, 1'b0};
                2'd2: v = {29'h0, m_ovr, m_done, m_busy(c)};
                default: v = {12'h0, m_result};
            endcase
        end
        return v;
    endfunction

    function automatic void m_write(int w, logic [31:0] adr, logic [3:0] sel, logic [31:0] dat);
        m_sync(w);
        if (m_hit(adr)) begin
            case (adr[3:2])
                2'd0: if (!m_busy(w)) begin
                    if (sel[0]) m_coef[7:0]  = dat[7:0];
                    if (sel[1]) m_coef[15:8] = dat[15:8];
                end
                2'd1: if (sel[0]) begin
                    m_irq_en = dat[1];
                    if (dat[0]) begin
                        if (m_idle(w)) begin
                            pending   = 1;
                            run_start = w + 1;
                            cap       = w + S + 1;
                            m_done    = 0;
                            cap_alpha = next_alpha;
                            alpha_drv = next_alpha;
                        end else begin
                            m_ovr = 1;
                        end
                    end
                end
                2'd2: if (sel[0]) begin
                    if (dat[1]) m_done = 0;
                    if (dat[2]) m_ovr  = 0;
                end
                default: ;
            endcase
        end
    endfunction

    task automatic check_pins();
        int c;
        c = cyc_cnt;
        m_sync(c);
        checks++;
        if (core_z !== m_coef) begin
            errors++;
            $display("FAIL core_z cycle %0d: got %h expected %h", c, core_z, m_coef);
        end
        checks++;
        if (irq !== (m_done & m_irq_en)) begin
            errors++;
            $display("FAIL irq cycle %0d: got %b expected %b", c, irq, m_done & m_irq_en);
        end
        if (m_busy(c) || m_idle(c)) begin
            checks++;
            if (core_rst !== m_idle(c)) begin
                errors++;
                $display("FAIL core_rst cycle %0d: got %b expected %b", c, core_rst, m_idle(c));
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check_pins();
        end
    endtask

    task automatic xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input string nm);
        int   r, w;
        bit   got;
        exp_t e;
        r = cyc_cnt;
        w = 0;
        m_sync(r);
        e.is_rd = !we;
        e.data  = we ? 32'h0 : m_read(r, adr);
        e.name  = nm;
        sb_q.push_back(e);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_sel_i = sel; wbs_dat_i = dat;
        got = 0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(posedge clk); #1;
            if (wbs_ack_o === 1'b1) begin
                got = 1;
                w = cyc_cnt;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout %s: no ack within 4 cycles of request at cycle %0d", nm, r);
            if (sb_q.size() > 0) void'(sb_q.pop_back());
        end else if (w != r + 1) begin
            errors++;
            $display("FAIL ack_latency %s: ack at cycle %0d expected %0d", nm, w, r + 1);
        end
        if (got) begin
            @(posedge clk); #1;
        end
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        if (got) begin
            $display("txn %s we=%0b adr=%h sel=%b dat=%h cycle=%0d", nm, we, adr, sel, dat, r);
            if (we) m_write(w, adr, sel, dat);
        end
        check_pins();
    endtask

    task automatic wr(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat, input string nm);
        xfer(1'b1, adr, sel, dat, nm);
    endtask

    task automatic rd(input logic [31:0] adr, input string nm);
        xfer(1'b0, adr, 4'hF, 32'h0, nm);
    endtask

    // Monitor: pops one expectation per ack and checks read data.
    bit prev_ack = 0;
    always @(negedge clk) begin
        exp_t e;
        if (wbs_ack_o === 1'b1) begin
            checks++;
            if (prev_ack) begin
                errors++;
                $display("FAIL ack_width: ack high on consecutive cycles at cycle %0d", cyc_cnt);
            end
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: ack with no outstanding request at cycle %0d", cyc_cnt);
            end else begin
                e = sb_q.pop_front();
                if (e.is_rd) begin
                    checks++;
                    if (wbs_dat_o !== e.data) begin
                        errors++;
                        $display("FAIL read %s: got %h expected %h", e.name, wbs_dat_o, e.data);
                    end
                end
            end
        end
        prev_ack = (wbs_ack_o === 1'b1);
    end

    initial begin
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        int          idx;
        bit          we;

        m_reset();
        next_alpha = 20'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        check_pins();

        // T1: reset values
        rd(BASE + 32'h0, "t1_coef");
        rd(BASE + 32'h4, "t1_ctrl");
        rd(BASE + 32'h8, "t1_status");
        rd(BASE + 32'hC, "t1_result");

        // T2: byte lanes on COEF
        wr(BASE, 4'b0001, 32'h0000_A5C3, "t2_coef_lo");
        rd(BASE, "t2_coef_lo_rd");
        wr(BASE, 4'b0011, 32'h0000_A5C3, "t2_coef_both");
        rd(BASE, "t2_coef_both_rd");

        // T3: full run with interrupt enabled
        next_alpha = 20'hABCDE;
        wr(BASE + 32'h4, 4'b0001, 32'h3, "t3_start");
        rd(BASE + 32'h8, "t3_status_busy");
        wr(BASE, 4'b0011, 32'h0000_1111, "t3_coef_while_busy");
        idle_cycles(S);
        rd(BASE + 32'h8, "t3_status_done");
        rd(BASE + 32'hC, "t3_result");
        rd(BASE + 32'h4, "t3_ctrl");

        // T4: restart while busy sets OVERRUN, then W1C
        next_alpha = 20'h12345;
        wr(BASE + 32'h4, 4'b0001, 32'h3, "t4_start");
        wr(BASE + 32'h4, 4'b0001, 32'h3, "t4_restart_busy");
        idle_cycles(S);
        rd(BASE + 32'h8, "t4_status_ovr");
        rd(BASE + 32'hC, "t4_result");
        wr(BASE + 32'h8, 4'b0001, 32'h6, "t4_w1c");
        rd(BASE + 32'h8, "t4_status_clr");

        // T5: asynchronous reset in the middle of a run
        next_alpha = 20'h55555;
        wr(BASE + 32'h4, 4'b0001, 32'h1, "t5_start");
        idle_cycles(2);
        #2 rst_n = 0;
        #1;
        checks++;
        if (core_rst !== 1'b1 || irq !== 1'b0) begin
            errors++;
            $display("FAIL t5_async_reset: core_rst=%b irq=%b expected 1 0", core_rst, irq);
        end
        @(posedge clk); #1;
        rst_n = 1;
        m_reset();
        check_pins();
        idle_cycles(S + 2);
        rd(BASE + 32'h8, "t5_status");
        rd(BASE + 32'hC, "t5_result");

        // T6: out-of-range addresses
        wr(BASE, 4'b0011, 32'h0000_BEEF, "t6_coef_set");
        rd(BASE + 32'h10, "t6_rd_above");
        rd(32'h2000_0000, "t6_rd_other_base");
        rd(BASE + 32'h2, "t6_rd_misaligned");
        wr(BASE + 32'h10, 4'b0011, 32'h0000_1234, "t6_wr_above");
        wr(32'h2000_0000, 4'b0011, 32'h0000_5678, "t6_wr_other_base");
        wr(BASE + 32'h5, 4'b0001, 32'h3, "t6_wr_misaligned_ctrl");
        rd(BASE, "t6_coef_kept");
        rd(BASE + 32'h8, "t6_status_kept");

        // Random traffic
        for (int n = 0; n < 250; n++) begin
            idx = $urandom_range(0, 3);
            case ($urandom_range(0, 11))
                0:       adr = BASE + 32'h10 + (idx << 2);
                1:       adr = 32'h2000_0000 | (idx << 2);
                2:       adr = BASE | (idx << 2) | $urandom_range(1, 3);
                default: adr = BASE | (idx << 2);
            endcase
            we = ($urandom_range(0, 1) == 1);
            sel = 4'($urandom);
            dat = $urandom;
            next_alpha = 20'($urandom);
            if (we) wr(adr, sel, dat, "rand_wr");
            else    rd(adr, "rand_rd");
            idle_cycles($urandom_range(0, 3));
        end
        idle_cycles(S + 3);
        rd(BASE + 32'h8, "final_status");
        rd(BASE + 32'hC, "final_result");
        rd(BASE, "final_coef");
        idle_cycles(2);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
